// File: rtl/mult_pkg.sv
// Shared types and sizing helpers for the shift-add multiplier controller.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    STEP = 2'd2,
    DONE = 2'd3
  } mult_state_t;

  localparam int MULT_WIDTH = 32;

  // The counter must be able to hold WIDTH itself, not just WIDTH-1.
  function automatic int iter_w(input int width);
    return $clog2(width + 1);
  endfunction

  localparam int ITER_W = iter_w(MULT_WIDTH);

endpackage

// File: rtl/mult_iter_counter.sv
// Iteration counter: synchronous clear, saturating increment, and a flag
// marking the last iteration (count == WIDTH-1).
module mult_iter_counter
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      clr,
  input  logic                      inc,
  output logic [iter_w(WIDTH)-1:0]  count,
  output logic                      last
);

  localparam int IW = iter_w(WIDTH);
  localparam logic [IW-1:0] CNT_MAX  = IW'(WIDTH);
  localparam logic [IW-1:0] CNT_LAST = IW'(WIDTH - 1);

  logic [IW-1:0] count_q;
  logic [IW-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != CNT_MAX)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign last  = (count_q == CNT_LAST);

endmodule

// File: rtl/mult_seq_ctrl.sv
// Sequencing FSM for the shift-add multiplier: LOAD, WIDTH add/shift steps
// (or fewer with early exit), then a one-cycle DONE pulse.
module mult_seq_ctrl
  import mult_pkg::*;
#(
  parameter int WIDTH      = MULT_WIDTH,
  parameter bit EARLY_EXIT = 1'b0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      mplier_lsb,
  input  logic                      mplier_zero,
  output logic                      busy,
  output logic                      done,
  output logic                      op_load,
  output logic                      prod_clear,
  output logic                      prod_write,
  output logic                      mcand_shift,
  output logic                      mplier_shift,
  output logic [iter_w(WIDTH)-1:0]  iter
);

  mult_state_t state_q, state_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic in_load;
  logic in_step;
  logic early_zero;
  logic step_act;
  logic iter_last;

  assign in_load    = (state_q == LOAD);
  assign in_step    = (state_q == STEP);
  assign early_zero = EARLY_EXIT && mplier_zero;
  // A step that finds no remaining multiplier bits does no datapath work.
  assign step_act   = in_step && !early_zero;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start) state_d = LOAD;
      LOAD: state_d = STEP;
      STEP: if (early_zero || iter_last) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  mult_iter_counter #(
    .WIDTH (WIDTH)
  ) u_iter (
    .clk   (clk),
    .reset (reset),
    .clr   (in_load),
    .inc   (step_act),
    .count (iter),
    .last  (iter_last)
  );

  // Multiplicand shift, multiplier shift and product accumulate share one
  // edge, so the accumulate uses the pre-shift multiplicand.
  assign busy         = busy_q;
  assign done         = done_q;
  assign op_load      = in_load;
  assign prod_clear   = in_load;
  assign mcand_shift  = step_act;
  assign mplier_shift = step_act;
  assign prod_write   = step_act && mplier_lsb;

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Table-driven bench for mult_seq_ctrl with a behavioural shift-add datapath
// attached; instance 0 has EARLY_EXIT=0, instance 1 has EARLY_EXIT=1.
module tb_mult_seq_ctrl;

  localparam int W  = 32;
  localparam int IW = $clog2(W + 1);

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic          start  [2];
  logic          busy   [2];
  logic          done   [2];
  logic          ld     [2];
  logic          pc     [2];
  logic          pw     [2];
  logic          ms     [2];
  logic          mr     [2];
  logic [IW-1:0] iter_o [2];
  logic          lsb    [2];
  logic          zero   [2];
  logic [31:0]   opa    [2];
  logic [31:0]   opb    [2];
  logic [63:0]   prod_o [2];

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    logic [63:0] mcand_q;
    logic [63:0] prod_q;
    logic [31:0] mplier_q;

    mult_seq_ctrl #(
      .WIDTH      (W),
      .EARLY_EXIT (gi == 1)
    ) u_dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start[gi]),
      .mplier_lsb   (lsb[gi]),
      .mplier_zero  (zero[gi]),
      .busy         (busy[gi]),
      .done         (done[gi]),
      .op_load      (ld[gi]),
      .prod_clear   (pc[gi]),
      .prod_write   (pw[gi]),
      .mcand_shift  (ms[gi]),
      .mplier_shift (mr[gi]),
      .iter         (iter_o[gi])
    );

    always_ff @(posedge clk) begin
      if (ld[gi]) begin
        mcand_q  <= {32'd0, opa[gi]};
        mplier_q <= opb[gi];
      end else begin
        if (ms[gi]) mcand_q <= mcand_q << 1;
        if (mr[gi]) mplier_q <= mplier_q >> 1;
      end
      if (pc[gi]) prod_q <= '0;
      else if (pw[gi]) prod_q <= prod_q + mcand_q;
    end

    assign lsb[gi]    = mplier_q[0];
    assign zero[gi]   = (mplier_q == 32'd0);
    assign prod_o[gi] = prod_q;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [6:0] ctrl(input int s);
    return {busy[s], done[s], ld[s], pc[s], pw[s], ms[s], mr[s]};
  endfunction

  // Per-cycle recording; index n is the cycle after edge n, edge 0 samples start.
  logic          r_busy [0:63];
  logic          r_done [0:63];
  logic          r_ld   [0:63];
  logic          r_pc   [0:63];
  logic          r_pw   [0:63];
  logic          r_ms   [0:63];
  logic [IW-1:0] r_iter [0:63];
  logic [63:0]   r_prod [0:63];

  task automatic run_op(input int sel, input logic [31:0] a, input logic [31:0] b,
                        input bit hold, input int poke, output int dcyc);
    opa[sel] = a;
    opb[sel] = b;
    @(negedge clk);
    start[sel] = 1'b1;
    dcyc = 0;
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      r_busy[n] = busy[sel];
      r_done[n] = done[sel];
      r_ld[n]   = ld[sel];
      r_pc[n]   = pc[sel];
      r_pw[n]   = pw[sel];
      r_ms[n]   = ms[sel];
      r_iter[n] = iter_o[sel];
      r_prod[n] = prod_o[sel];
      if (done[sel] && dcyc == 0) dcyc = n;
      start[sel] = hold || (n == poke);
      if (dcyc != 0 && n >= dcyc + 3) break;
    end
    if (dcyc == 0) begin
      errors++;
      checks++;
      $display("FAIL timeout: done not seen within 60 cycles (inst %0d)", sel);
    end
  endtask

  typedef struct {
    int          sel;
    logic [31:0] a;
    logic [31:0] b;
    int          poke;
    int          exp_done;
    logic [63:0] exp_prod;
    int          exp_pw;
    int          exp_ms;
    int          exp_iter;
  } vec_t;

  vec_t vecs [7];

  initial begin
    int d;
    int n_pw, n_ms, n_ld, n_busy, n_done, n_ovl;
    bit found;

    start[0] = 1'b0;
    start[1] = 1'b0;
    opa[0] = '0; opb[0] = '0; opa[1] = '0; opb[1] = '0;

    vecs[0] = '{0, 32'h0000_000D, 32'h0000_000B, -1, 34, 64'd143, 3, 32, 32};
    vecs[1] = '{0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, 34, 64'hFFFF_FFFE_0000_0001, 32, 32, 32};
    vecs[2] = '{0, 32'h0000_0007, 32'h0000_000A, -1, 34, 64'd70, 2, 32, 32};
    vecs[3] = '{0, 32'h0000_0000, 32'h0000_0000, -1, 34, 64'd0, 0, 32, 32};
    vecs[4] = '{1, 32'h0000_0009, 32'h0000_0005, -1, 6, 64'd45, 2, 3, 3};
    vecs[5] = '{1, 32'h0000_1234, 32'h0000_0000, -1, 3, 64'd0, 0, 0, 0};
    vecs[6] = '{1, 32'h0000_0003, 32'h8000_0000, 10, 34, 64'h1_8000_0000, 1, 32, 32};

    repeat (3) @(negedge clk);
    chk("reset_ctrl0", ctrl(0), 7'd0);
    chk("reset_ctrl1", ctrl(1), 7'd0);
    chk("reset_iter0", iter_o[0], 0);
    reset = 1'b1;
    @(negedge clk);
    chk("idle_ctrl0", ctrl(0), 7'd0);

    foreach (vecs[v]) begin
      run_op(vecs[v].sel, vecs[v].a, vecs[v].b, 1'b0, vecs[v].poke, d);
      $display("vec %0d: inst %0d 0x%08h x 0x%08h -> done cycle %0d product 0x%016h",
               v, vecs[v].sel, vecs[v].a, vecs[v].b, d, (d > 0) ? r_prod[d] : 64'd0);
      if (d == 0) continue;
      n_pw = 0; n_ms = 0; n_ld = 0; n_busy = 0; n_done = 0; n_ovl = 0;
      for (int n = 1; n <= d; n++) begin
        n_pw   += int'(r_pw[n]);
        n_ms   += int'(r_ms[n]);
        n_ld   += int'(r_ld[n]);
        n_busy += int'(r_busy[n]);
        n_done += int'(r_done[n]);
        n_ovl  += int'(r_ld[n] & r_ms[n]);
      end
      chk($sformatf("v%0d_done_cycle", v), d, vecs[v].exp_done);
      chk($sformatf("v%0d_product", v), r_prod[d], vecs[v].exp_prod);
      chk($sformatf("v%0d_iter_at_done", v), r_iter[d], vecs[v].exp_iter);
      chk($sformatf("v%0d_prod_write_cnt", v), n_pw, vecs[v].exp_pw);
      chk($sformatf("v%0d_mcand_shift_cnt", v), n_ms, vecs[v].exp_ms);
      chk($sformatf("v%0d_load_cycle1", v), {r_ld[1], r_pc[1]}, 2'b11);
      chk($sformatf("v%0d_load_cnt", v), n_ld, 1);
      chk($sformatf("v%0d_busy_cnt", v), n_busy, d);
      chk($sformatf("v%0d_done_cnt", v), n_done, 1);
      chk($sformatf("v%0d_load_shift_overlap", v), n_ovl, 0);
      chk($sformatf("v%0d_idle_after", v), {r_busy[d+1], r_busy[d+3], r_ld[d+2]}, 3'b000);
      // Multiplier 0xA: bits set at iterations 2 and 4, i.e. cycles 3 and 5.
      if (v == 2) chk("v2_pw_pattern", {r_pw[2], r_pw[3], r_pw[4], r_pw[5]}, 4'b0101);
    end

    // start held high: one IDLE cycle after done, then a fresh LOAD.
    run_op(0, 32'd2, 32'd3, 1'b1, -1, d);
    $display("held start: done cycle %0d", d);
    chk("hold_done_cycle", d, 34);
    chk("hold_idle_gap", {r_busy[35], r_ld[35]}, 2'b00);
    chk("hold_reload", {r_busy[36], r_ld[36]}, 2'b11);
    start[0] = 1'b0;
    found = 1'b0;
    for (int n = 0; n < 50 && !found; n++) begin
      @(negedge clk);
      if (done[0]) found = 1'b1;
    end
    chk("hold_second_done", found, 1'b1);
    @(negedge clk);

    // Asynchronous reset during STEP with iter == 10.
    opa[0] = 32'h1234_5678;
    opb[0] = 32'hFFFF_FFFF;
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    found = 1'b0;
    for (int n = 0; n < 40 && !found; n++) begin
      @(negedge clk);
      if (iter_o[0] == IW'(10)) found = 1'b1;
    end
    chk("midop_reached_iter10", found, 1'b1);
    chk("midop_shifting", {busy[0], ms[0]}, 2'b11);
    #2 reset = 1'b0;
    #1;
    $display("mid-op reset: ctrl=0x%0h iter=%0d", ctrl(0), iter_o[0]);
    chk("midop_reset_ctrl", ctrl(0), 7'd0);
    chk("midop_reset_iter", iter_o[0], 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      chk($sformatf("post_reset_idle%0d", n), {busy[0], ld[0], iter_o[0]}, '0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mult_seq_ctrl.md
# mult_seq_ctrl

Sequencing FSM for the shift-add multiplier datapath. It drives the multiplicand register (load / shift-left), the multiplier register (load / shift-right) and the product register (clear / accumulate-write). It runs one add-and-shift iteration per clock for WIDTH iterations. A start/busy/done handshake lets the issuing unit launch a multiply and collect the result.

## Interface
Parameters:
- WIDTH, 32, operand width; also the maximum iteration count.
- EARLY_EXIT, 0, when 1, finish as soon as the remaining multiplier bits are all zero.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low.
- start  in  1  request a multiply; sampled only in IDLE.
- mplier_lsb  in  1  bit 0 of the multiplier register.
- mplier_zero  in  1  multiplier register == 0; used only when EARLY_EXIT=1.
- busy  out  1  high from the cycle after start is accepted until the DONE cycle inclusive.
- done  out  1  one-cycle pulse; product register is final.
- op_load  out  1  load multiplicand and multiplier registers from operand buses.
- prod_clear  out  1  clear product register.
- prod_write  out  1  product <= product + multiplicand.
- mcand_shift  out  1  shift multiplicand left by 1.
- mplier_shift  out  1  shift multiplier right by 1.
- iter  out  $clog2(WIDTH+1)  iterations completed in the current operation.

## Operation
- States: IDLE, LOAD, STEP, DONE.
- IDLE:
  - All control outputs are 0.
  - start=1 -> LOAD.
  - iter holds its last value.
- LOAD, one cycle:
  - op_load=1 and prod_clear=1; iter <= 0.
  - -> STEP.
- STEP, one cycle per iteration:
  - mcand_shift=1 and mplier_shift=1.
  - prod_write=mplier_lsb.
  - iter <= iter+1.
  - All three register updates happen on the same edge, so the adder sees the pre-shift multiplicand.
  - Exit -> DONE when iter==WIDTH-1, i.e. the WIDTH-th step.
  - EARLY_EXIT=1 and mplier_zero=1 at STEP entry: all control outputs are 0 that cycle, no iter increment, -> DONE.
- DONE, one cycle:
  - done=1 and busy=1.
  - -> IDLE.
- start while not IDLE is ignored; it is not queued.
- op_load and mcand_shift are never asserted together. The downstream register gives load priority, but the controller must not rely on that.
- Product width is the datapath's concern (2*WIDTH). The controller is width-agnostic except for the iteration count.

## Timing
- Reset (asynchronous, any state, including mid-STEP):
  - State -> IDLE.
  - All outputs 0, iter=0.
  - Release takes effect on the next rising edge.
- start sampled high at edge 0: LOAD during cycle 1, STEP cycles 2..WIDTH+1, done high in cycle WIDTH+2.
  - Total latency start->done = WIDTH+2 cycles.
  - Next start is accepted no earlier than the cycle after done.
- EARLY_EXIT=1: latency = 3 + k cycles, where k is the number of STEP iterations executed before mplier_zero is seen.
  - Multiplier zero at load gives k=0 and latency 3.
- start held high continuously: back-to-back operations with one IDLE cycle between done and the next LOAD.
- busy is a registered function of state (not IDLE). No combinational path from start to any output.
- iter saturates at WIDTH and never wraps.

## Structure
- Package mult_pkg holds:
  - the state enum (IDLE, LOAD, STEP, DONE) as a typedef;
  - MULT_WIDTH default constant (32);
  - an ITER_W localparam helper.
- Sub-module mult_iter_counter: synchronous clear plus increment counter of width ITER_W, with terminal-count flag (iter==WIDTH-1), asynchronous active-low reset.
- FSM next-state and output decode stay in mult_seq_ctrl. Outputs are decoded from the registered state plus mplier_lsb and mplier_zero only.

## Test plan
- Reset mid-operation: assert reset at STEP iter=10 -> all outputs 0 immediately and iter=0. After release with start=0, stays IDLE.
- Full run, WIDTH=32, start pulse at cycle 0 -> LOAD in cycle 1; 32 STEP cycles; done=1 only in cycle 34; busy high cycles 1-34.
- With datapath attached, operands 0x0000_000D x 0x0000_000B -> product 143 at done. Also check 0xFFFF_FFFF x 0xFFFF_FFFF -> 0xFFFF_FFFE_0000_0001.
- Multiplier pattern 0xA (LSBs 0,1,0,1) -> prod_write high exactly in STEP cycles 2 and 4. Also check mcand_shift high in all 32 STEP cycles.
- EARLY_EXIT=1, multiplier 0x5 -> 3 STEP cycles then DONE, done at cycle 6. Multiplier 0 -> done at cycle 3, no prod_write.
- start asserted during STEP is ignored. start held high through done -> one IDLE cycle, then a new LOAD.
